// File: rtl/montgomery_op_sequencer.sv
// Computes y = a*b mod m with four back-to-back Montgomery products on one shared core.
// Optional watchdog per core operation: define MONT_SEQ_TIMEOUT_EN.
module montgomery_op_sequencer #(
    parameter int NBITS      = 2048,
    parameter int TMO_CYCLES = 65535
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable_p,
    input  logic [NBITS-1:0] i_a,
    input  logic [NBITS-1:0] i_b,
    input  logic [NBITS-1:0] i_m,
    input  logic [NBITS-1:0] i_r_red,
    input  logic [10:0]      i_m_size,
    output logic [NBITS-1:0] o_y,
    output logic             o_done_irq_p,
    output logic             o_busy,
    output logic [2:0]       o_phase,
    output logic             o_err_timeout_p,
    output logic             o_core_enable_p,
    output logic [NBITS-1:0] o_core_a,
    output logic [NBITS-1:0] o_core_b,
    output logic [NBITS-1:0] o_core_m,
    output logic [10:0]      o_core_m_size,
    input  logic [NBITS-1:0] i_core_y,
    input  logic             i_core_done_irq_p
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV_A = 3'd1,
        ST_CONV_B = 3'd2,
        ST_MUL    = 3'd3,
        ST_FROM   = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_issue;
    logic [NBITS-1:0] r_b;
    logic [NBITS-1:0] r_r_red;
    logic [NBITS-1:0] r_ar;
    logic [NBITS-1:0] r_y;
    logic             r_done;
    logic             r_busy;
    logic             r_err;
    logic             r_core_en;
    logic [NBITS-1:0] r_core_a;
    logic [NBITS-1:0] r_core_b;
    logic [NBITS-1:0] r_core_m;
    logic [10:0]      r_core_m_size;
    logic             w_tmo;

`ifdef MONT_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYCLES + 1);
    logic [CW-1:0] r_wait_cnt;

    // Counts completed WAIT cycles; the limit is hit on the TMO_CYCLES-th one.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_IDLE || r_issue) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_tmo = (r_state != ST_IDLE) && !r_issue && (r_wait_cnt == CW'(TMO_CYCLES - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_issue       <= 1'b0;
            r_b           <= '0;
            r_r_red       <= '0;
            r_ar          <= '0;
            r_y           <= '0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
            r_core_en     <= 1'b0;
            r_core_a      <= '0;
            r_core_b      <= '0;
            r_core_m      <= '0;
            r_core_m_size <= '0;
        end else begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_core_en <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (i_enable_p) begin
                    r_b           <= i_b;
                    r_r_red       <= i_r_red;
                    r_core_m      <= i_m;
                    r_core_m_size <= i_m_size;
                    r_core_a      <= i_a;
                    r_core_b      <= i_r_red;
                    r_core_en     <= 1'b1;
                    r_issue       <= 1'b1;
                    r_busy        <= 1'b1;
                    r_state       <= ST_CONV_A;
                end
            end else if (r_issue) begin
                r_issue <= 1'b0;
            end else if (i_core_done_irq_p) begin
                // Capture the result and launch the next product in the same edge.
                case (r_state)
                    ST_CONV_A: begin
                        r_ar      <= i_core_y;
                        r_core_a  <= r_b;
                        r_core_b  <= r_r_red;
                        r_core_en <= 1'b1;
                        r_issue   <= 1'b1;
                        r_state   <= ST_CONV_B;
                    end
                    ST_CONV_B: begin
                        r_core_a  <= r_ar;
                        r_core_b  <= i_core_y;
                        r_core_en <= 1'b1;
                        r_issue   <= 1'b1;
                        r_state   <= ST_MUL;
                    end
                    ST_MUL: begin
                        r_core_a  <= i_core_y;
                        r_core_b  <= NBITS'(1);
                        r_core_en <= 1'b1;
                        r_issue   <= 1'b1;
                        r_state   <= ST_FROM;
                    end
                    ST_FROM: begin
                        r_y     <= i_core_y;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end else if (w_tmo) begin
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
            end
        end
    end

    assign o_y             = r_y;
    assign o_done_irq_p    = r_done;
    assign o_busy          = r_busy;
    assign o_phase         = r_state;
    assign o_err_timeout_p = r_err;
    assign o_core_enable_p = r_core_en;
    assign o_core_a        = r_core_a;
    assign o_core_b        = r_core_b;
    assign o_core_m        = r_core_m;
    assign o_core_m_size   = r_core_m_size;

endmodule

// File: doc/montgomery_op_sequencer.md
# montgomery_op_sequencer

Sequencer that computes y = a·b mod m on a single shared Montgomery multiplier core instead of four chained instances. It runs four Montgomery products back-to-back on that core, storing intermediates in local registers. The products are: to-domain conversion of a, to-domain conversion of b, the domain product, and from-domain conversion. It sits between the host-side operand interface and one core that uses the codebase pulse handshake (core enable in, done_irq out).

## Interface
- NBITS, 2048, operand and modulus width
- TMO_CYCLES, 65535, watchdog limit in cycles per core operation; only used with the timeout feature
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- enable_p  in  1  start pulse; sampled only in IDLE
- a, b, m, r_red  in  NBITS each  operands, modulus, and R² mod m (R = 2^NBITS)
- m_size  in  11  modulus bit size, forwarded to core
- y  out  NBITS  result a·b mod m
- done_irq_p  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after an accepted start until done/abort
- phase  out  3  current state encoding, for debug
- err_timeout_p  out  1  one-cycle watchdog abort pulse
- core_enable_p  out  1  start pulse to core, registered
- core_a, core_b, core_m  out  NBITS each  core operands, registered
- core_m_size  out  11  registered
- core_y  in  NBITS  core result
- core_done_irq_p  in  1  core completion pulse

## Operation
- States and phase codes: IDLE=0, CONV_A=1, CONV_B=2, MUL=3, FROM=4.
- Each non-IDLE state has two sub-steps: ISSUE, then WAIT.
  - ISSUE lasts one cycle, with core_enable_p=1 and core_a/core_b driven.
  - WAIT continues until core_done_irq_p=1. On that edge, core_y is captured and the sequencer moves to the next state's ISSUE.
- Start: IDLE with enable_p=1 latches a, b, m, m_size and r_red into local registers. The sequencer then enters CONV_A.
- Operands per state:
  - CONV_A: core_a=a_lat, core_b=r_red_lat; result goes to ar.
  - CONV_B: core_a=b_lat, core_b=r_red_lat; result goes to br.
  - MUL: core_a=ar, core_b=br; result goes to pr.
  - FROM: core_a=pr, core_b=1, zero-extended to NBITS; result goes to y.
- core_m and core_m_size hold the latched values for the whole operation.
- After the FROM capture: done_irq_p=1 for one cycle and the sequencer returns to IDLE. y holds its value until the next completion or reset.
- Ignored inputs:
  - enable_p while busy: no effect, not queued.
  - core_done_irq_p in IDLE or in an ISSUE cycle: no effect.
- Reset values: every output is 0, including y, phase and the core_* buses. All internal registers are also 0.
- Reset mid-operation: the sequencer is in IDLE on the next edge. A later core_done_irq_p from the abandoned operation is ignored. done_irq_p is never asserted for an aborted operation.
- Arithmetic: the block performs no arithmetic. Correctness relies on the core computing x·y·R⁻¹ mod m for inputs below m.

## Timing
- Define L = core latency: done arrives L cycles after core_enable_p, with L ≥ 1.
- With enable_p high in cycle 0:
  - ISSUE for operation k (k = 1..4) occurs in cycle 1+(k−1)(L+1).
  - done_irq_p occurs in cycle 5+4L. Example: L=3 gives done_irq_p in cycle 17.
- busy is 1 from cycle 1 through cycle 4+4L.
- y updates on the same edge on which done_irq_p rises, so both are visible in the same cycle.
- A new enable_p is accepted in the done_irq_p cycle or later, because the block is already in IDLE in that cycle.

## Configuration
- MONT_SEQ_TIMEOUT_EN defined:
  - A wait counter clears at each ISSUE and increments in WAIT.
  - If the counter reaches TMO_CYCLES without core_done_irq_p, the sequencer asserts err_timeout_p for one cycle and returns to IDLE.
  - On timeout, y is unchanged and done_irq_p is not asserted.
  - A core_done_irq_p on the same edge as the limit counts as success.
- MONT_SEQ_TIMEOUT_EN undefined: there is no counter, WAIT is unbounded, and err_timeout_p is tied to 0. The port remains present.

## Test plan
All scenarios use NBITS=8, m=97, r_red=61 and a behavioural core model with L=3.
- a=5, b=7, enable_p → y=35 and done_irq_p in cycle 17; core operands observed in order (5,61), (7,61), (ar,br), (pr,1).
- a=96, b=96 → y=1. Then a=0, b=50 → y=0. Run both back-to-back, with the second start in the first operation's done_irq_p cycle → both results correct.
- enable_p pulsed at cycles 4 and 9 during an operation → ignored: exactly one done_irq_p, y=35.
- rst_n low in cycle 6 of an operation → all outputs 0 the next cycle. The model's pending done is ignored and no done_irq_p follows.
- Core model with random L in 1..10 per operation → result is correct and done_irq_p arrives one cycle after the FROM done.
- Run only with MONT_SEQ_TIMEOUT_EN and TMO_CYCLES=20: the core model never answers in MUL → err_timeout_p pulses, the sequencer returns to IDLE, and y keeps its previous value.
